// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_access_stage_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int DATA_W      = 32;
   localparam int INS_ID_W    = 3;
   localparam int REG_W       = 5;
   localparam int CTR_W       = 8;
   localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and memory.
interface mem_access_stage_if;
   import mem_access_stage_pkg::*;

   logic              dm_req;
   logic              dm_we;
   logic [DATA_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ack;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_rdata, dm_ack
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_rdata, dm_ack
   );

endinterface

// File: rtl/mem_timeout_ctr.sv
// 8-bit clear/enable counter; tc flags the cycle the count equals TC_VAL.
module mem_timeout_ctr
   import mem_access_stage_pkg::*;
#(
   parameter logic [CTR_W-1:0] TC_VAL = CTR_W'(TIMEOUT_DEF - 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CTR_W-1:0] count;

   // Count enabled cycles; clear has priority over enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      count <= '0;
      else if (clr) count <= '0;
      else if (en)  count <= count + 1'b1;
   end

   assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: ALU results retire in one cycle; loads/stores run a
// req/ack transaction on the data bus with a timeout and sticky error.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   aluresult_in,
   input  logic [DATA_W-1:0]   regdata2_in,
   input  logic [REG_W-1:0]    wrreg_in,
   input  logic                MemWrite_in,
   input  logic                MemtoReg_in,
   input  logic                RegWrite_in,
   input  logic [INS_ID_W-1:0] INS_ID_in,
   mem_access_stage_if.master  dm,
   output logic                mem_stall,
   output logic                wb_valid,
   output logic [DATA_W-1:0]   wb_data,
   output logic [REG_W-1:0]    wb_reg,
   output logic                wb_RegWrite,
   output logic [INS_ID_W-1:0] INS_ID_out,
   output logic                bus_err
);

   state_t state, state_nxt;

   logic                mem_op;
   logic                accept_alu, accept_mem, misalign;
   logic                done_ack, done_to;
   logic                tc;

   // Captured instruction context for the memory transaction in flight.
   logic                load_p1;
   logic                regwrite_p1;
   logic [REG_W-1:0]    wrreg_p1;
   logic [INS_ID_W-1:0] ins_id_p1;

   // A load/store with both bits set behaves as a store.
   assign mem_op     = MemWrite_in | MemtoReg_in;
   assign accept_alu = (state == IDLE) && in_valid && !mem_op;
   assign accept_mem = (state == IDLE) && in_valid && mem_op && (aluresult_in[1:0] == 2'b00);
   assign misalign   = (state == IDLE) && in_valid && mem_op && (aluresult_in[1:0] != 2'b00);
   // Ack beats timeout when both land in the same cycle.
   assign done_ack   = (state == WAIT) && dm.dm_ack;
   assign done_to    = (state == WAIT) && !dm.dm_ack && tc;
   assign mem_stall  = (state == WAIT);

   mem_timeout_ctr #(
      .TC_VAL(CTR_W'(TIMEOUT - 1))
   ) u_timeout_ctr (
      .clk (clk),
      .rst (rst),
      .clr (accept_mem),
      .en  (state == WAIT),
      .tc  (tc)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_mem)          state_nxt = WAIT;
         WAIT:    if (done_ack || done_to) state_nxt = IDLE;
         default:                          state_nxt = IDLE;
      endcase
   end

   // Capture the instruction context when a memory access is launched.
   always_ff @(posedge clk) begin
      if (accept_mem) begin
         load_p1     <= !MemWrite_in;
         regwrite_p1 <= RegWrite_in;
         wrreg_p1    <= wrreg_in;
         ins_id_p1   <= INS_ID_in;
      end
   end

   // Data-bus outputs: launched on accept, held through WAIT, req dropped on completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dm.dm_req   <= 1'b0;
         dm.dm_we    <= 1'b0;
         dm.dm_addr  <= '0;
         dm.dm_wdata <= '0;
      end else if (accept_mem) begin
         dm.dm_req   <= 1'b1;
         dm.dm_we    <= MemWrite_in;
         dm.dm_addr  <= aluresult_in;
         dm.dm_wdata <= regdata2_in;
      end else if (done_ack || done_to) begin
         dm.dm_req   <= 1'b0;
      end
   end

   // Write-back outputs and sticky error; dm_addr doubles as the captured ALU result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid    <= 1'b0;
         wb_data     <= '0;
         wb_reg      <= '0;
         wb_RegWrite <= 1'b0;
         INS_ID_out  <= '0;
         bus_err     <= 1'b0;
      end else begin
         wb_valid <= accept_alu || misalign || done_ack || done_to;
         bus_err  <= bus_err | misalign | done_to;
         if (accept_alu || misalign) begin
            wb_data     <= aluresult_in;
            wb_reg      <= wrreg_in;
            INS_ID_out  <= INS_ID_in;
            wb_RegWrite <= accept_alu && RegWrite_in && (wrreg_in != '0);
         end else if (done_ack || done_to) begin
            wb_data     <= (done_ack && load_p1) ? dm.dm_rdata : dm.dm_addr;
            wb_reg      <= wrreg_p1;
            INS_ID_out  <= ins_id_p1;
            wb_RegWrite <= done_ack && load_p1 && regwrite_p1 && (wrreg_p1 != '0);
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] aluresult_in;
   logic [31:0] regdata2_in;
   logic [4:0]  wrreg_in;
   logic        MemWrite_in, MemtoReg_in, RegWrite_in;
   logic [2:0]  INS_ID_in;
   logic        mem_stall, wb_valid, wb_RegWrite, bus_err;
   logic [31:0] wb_data;
   logic [4:0]  wb_reg;
   logic [2:0]  INS_ID_out;

   int checks = 0;
   int errors = 0;
   int req_cnt, stall_cnt;

   mem_access_stage_if dm_bus ();

   mem_access_stage #(.TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .aluresult_in (aluresult_in),
      .regdata2_in  (regdata2_in),
      .wrreg_in     (wrreg_in),
      .MemWrite_in  (MemWrite_in),
      .MemtoReg_in  (MemtoReg_in),
      .RegWrite_in  (RegWrite_in),
      .INS_ID_in    (INS_ID_in),
      .dm           (dm_bus),
      .mem_stall    (mem_stall),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .wb_reg       (wb_reg),
      .wb_RegWrite  (wb_RegWrite),
      .INS_ID_out   (INS_ID_out),
      .bus_err      (bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                        input logic mw, input logic m2r, input logic rw, input logic [2:0] id);
      in_valid     = 1'b1;
      aluresult_in = addr;
      regdata2_in  = data;
      wrreg_in     = rd;
      MemWrite_in  = mw;
      MemtoReg_in  = m2r;
      RegWrite_in  = rw;
      INS_ID_in    = id;
      step();
      in_valid     = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"},   {31'd0, dm_bus.dm_req}, 32'd0);
      check({tag, "_we"},    {31'd0, dm_bus.dm_we},  32'd0);
      check({tag, "_addr"},  dm_bus.dm_addr,         32'd0);
      check({tag, "_wdata"}, dm_bus.dm_wdata,        32'd0);
      check({tag, "_stall"}, {31'd0, mem_stall},     32'd0);
      check({tag, "_wbv"},   {31'd0, wb_valid},      32'd0);
      check({tag, "_wbd"},   wb_data,                32'd0);
      check({tag, "_wbr"},   {27'd0, wb_reg},        32'd0);
      check({tag, "_wbrw"},  {31'd0, wb_RegWrite},   32'd0);
      check({tag, "_id"},    {29'd0, INS_ID_out},    32'd0);
      check({tag, "_err"},   {31'd0, bus_err},       32'd0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; aluresult_in = '0; regdata2_in = '0; wrreg_in = '0;
      MemWrite_in = 1'b0; MemtoReg_in = 1'b0; RegWrite_in = 1'b0; INS_ID_in = '0;
      dm_bus.dm_ack = 1'b0; dm_bus.dm_rdata = '0;
      #12;
      check_all_zero("reset");
      step();
      rst = 1'b0;

      // ALU op retires one cycle later without touching the bus
      issue(32'h10, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 3'd1);
      check("alu_wbv",  {31'd0, wb_valid},      32'd1);
      check("alu_wbd",  wb_data,                32'h10);
      check("alu_wbr",  {27'd0, wb_reg},        32'd3);
      check("alu_wbrw", {31'd0, wb_RegWrite},   32'd1);
      check("alu_id",   {29'd0, INS_ID_out},    32'd1);
      check("alu_req",  {31'd0, dm_bus.dm_req}, 32'd0);
      step();
      check("alu_pulse", {31'd0, wb_valid}, 32'd0);
      check("alu_hold",  wb_data,           32'h10);

      // Load from 0x100, ack in the fourth WAIT cycle
      issue(32'h100, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1, 3'd2);
      check("ld_we",   {31'd0, dm_bus.dm_we}, 32'd0);
      check("ld_addr", dm_bus.dm_addr,        32'h100);
      req_cnt = 0; stall_cnt = 0;
      for (int i = 0; i < 20 && dm_bus.dm_req; i++) begin
         req_cnt++;
         stall_cnt += int'(mem_stall);
         if (req_cnt == 4) begin
            dm_bus.dm_ack = 1'b1;
            dm_bus.dm_rdata = 32'hDEADBEEF;
         end
         step();
         dm_bus.dm_ack = 1'b0;
      end
      check("ld_req_cycles",   req_cnt,   32'd4);
      check("ld_stall_cycles", stall_cnt, 32'd4);
      check("ld_wbv",  {31'd0, wb_valid},    32'd1);
      check("ld_wbd",  wb_data,              32'hDEADBEEF);
      check("ld_wbr",  {27'd0, wb_reg},      32'd5);
      check("ld_wbrw", {31'd0, wb_RegWrite}, 32'd1);
      check("ld_id",   {29'd0, INS_ID_out},  32'd2);
      step();
      check("ld_bubble", {31'd0, wb_valid}, 32'd0);

      // Store to 0x104 with immediate ack
      issue(32'h104, 32'h12345678, 5'd7, 1'b1, 1'b0, 1'b1, 3'd3);
      check("st_req",   {31'd0, dm_bus.dm_req}, 32'd1);
      check("st_we",    {31'd0, dm_bus.dm_we},  32'd1);
      check("st_wdata", dm_bus.dm_wdata,        32'h12345678);
      check("st_addr",  dm_bus.dm_addr,         32'h104);
      dm_bus.dm_ack = 1'b1;
      step();
      dm_bus.dm_ack = 1'b0;
      check("st_wbv",  {31'd0, wb_valid},      32'd1);
      check("st_wbrw", {31'd0, wb_RegWrite},   32'd0);
      check("st_wbd",  wb_data,                32'h104);
      check("st_req0", {31'd0, dm_bus.dm_req}, 32'd0);
      check("st_err",  {31'd0, bus_err},       32'd0);
      step();

      // Load to r0 never writes the register file
      issue(32'h108, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 3'd4);
      dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'hA5A5A5A5;
      step();
      dm_bus.dm_ack = 1'b0;
      check("r0_wbv",  {31'd0, wb_valid},    32'd1);
      check("r0_wbd",  wb_data,              32'hA5A5A5A5);
      check("r0_wbrw", {31'd0, wb_RegWrite}, 32'd0);
      step();

      // MemWrite and MemtoReg both set: handled as a store
      issue(32'h10C, 32'h55, 5'd9, 1'b1, 1'b1, 1'b1, 3'd6);
      check("both_we", {31'd0, dm_bus.dm_we}, 32'd1);
      dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'h77777777;
      step();
      dm_bus.dm_ack = 1'b0;
      check("both_wbrw", {31'd0, wb_RegWrite}, 32'd0);
      check("both_wbd",  wb_data,              32'h10C);
      step();

      // Load with no ack times out after 16 WAIT cycles
      issue(32'h200, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 3'd7);
      req_cnt = 0;
      for (int i = 0; i < 40 && dm_bus.dm_req; i++) begin
         req_cnt++;
         step();
      end
      check("to_req_cycles", req_cnt,              32'd16);
      check("to_err",   {31'd0, bus_err},          32'd1);
      check("to_wbv",   {31'd0, wb_valid},         32'd1);
      check("to_wbrw",  {31'd0, wb_RegWrite},      32'd0);
      check("to_stall", {31'd0, mem_stall},        32'd0);
      dm_bus.dm_ack = 1'b1;
      step();
      dm_bus.dm_ack = 1'b0;
      check("idle_ack_wbv", {31'd0, wb_valid},      32'd0);
      check("idle_ack_req", {31'd0, dm_bus.dm_req}, 32'd0);

      // Reset in the second WAIT cycle clears everything at once
      issue(32'h300, 32'h0, 5'd2, 1'b0, 1'b1, 1'b1, 3'd1);
      step();
      check("rw_stall", {31'd0, mem_stall}, 32'd1);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      step();
      rst = 1'b0;
      dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'hCAFEF00D;
      step();
      dm_bus.dm_ack = 1'b0;
      check("late_ack_wbv", {31'd0, wb_valid},  32'd0);
      check("late_ack_wbd", wb_data,            32'd0);

      // Misaligned load: no bus request, error and non-writing retire
      issue(32'h102, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1, 3'd5);
      check("mis_req",  {31'd0, dm_bus.dm_req}, 32'd0);
      check("mis_err",  {31'd0, bus_err},       32'd1);
      check("mis_wbv",  {31'd0, wb_valid},      32'd1);
      check("mis_wbrw", {31'd0, wb_RegWrite},   32'd0);
      check("mis_wbr",  {27'd0, wb_reg},        32'd6);
      check("mis_id",   {29'd0, INS_ID_out},    32'd5);
      step();
      check("mis_pulse",  {31'd0, wb_valid}, 32'd0);
      check("err_sticky", {31'd0, bus_err},  32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
